// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared encodings for the interpolation adder sequencer
package interp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_EST = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // add2_a operand select codes
    localparam logic [2:0] SEL_2E1  = 3'b000;
    localparam logic [2:0] SEL_E1   = 3'b001;
    localparam logic [2:0] SEL_2E2  = 3'b011;
    localparam logic [2:0] SEL_4E4  = 3'b010;
    localparam logic [2:0] SEL_NE3  = 3'b110;
    localparam logic [2:0] SEL_REG  = 3'b100;
    localparam logic [2:0] SEL_ZERO = 3'b111;

    // reg_E scaling codes; zero means scaling is unused on that step
    localparam logic [1:0] SH_NONE  = 2'd0;
    localparam logic [1:0] SH_ONE   = 2'd1;
    localparam logic [1:0] SH_HALF  = 2'd2;

    localparam logic [2:0] LAST_STEP = 3'd6;

endpackage

// File: rtl/interp_add_seq.sv
// rtl/interp_add_seq.sv - micro-program sequencer for the interpolation adder
module interp_add_seq
    import interp_pkg::*;
#(
    parameter int NUM_PASS = 2,
    parameter int PASS_W   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              est_valid,
    output logic              est_ack,
    output logic [2:0]        sel,
    output logic [1:0]        shift,
    output logic              reg_load,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        step_idx,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done
);

    state_t              r_state;
    logic [2:0]          r_step_idx;
    logic [PASS_W-1:0]   r_pass_idx;
    logic [2:0]          r_sel;
    logic [1:0]          r_shift;
    logic                r_reg_load;
    logic                r_out_valid;
    logic                r_est_ack;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_next;
    logic [2:0]          w_step_next;
    logic [PASS_W-1:0]   w_pass_next;
    logic                w_est_ack_next;
    logic                w_done_next;
    logic                w_busy_next;
    logic                w_advance;

    logic [2:0]          w_prog_sel;
    logic [1:0]          w_prog_shift;
    logic                w_prog_load;
    logic                w_prog_emit;

    logic [2:0]          w_sel_next;
    logic [1:0]          w_shift_next;
    logic                w_load_next;
    logic                w_valid_next;

    // r_out_valid is high exactly on emit steps in RUN, so it doubles as the emit flag
    assign w_advance = !r_out_valid || out_ready;

    // Next state, step and pass bookkeeping
    always_comb begin
        w_state_next   = r_state;
        w_step_next    = r_step_idx;
        w_pass_next    = r_pass_idx;
        w_est_ack_next = 1'b0;
        w_done_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_WAIT_EST;
                    w_pass_next  = '0;
                    w_step_next  = 3'd0;
                end
            end
            ST_WAIT_EST: begin
                if (est_valid) begin
                    w_state_next   = ST_RUN;
                    w_step_next    = 3'd0;
                    w_est_ack_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_advance) begin
                    if (r_step_idx == LAST_STEP) begin
                        w_step_next = 3'd0;
                        if (r_pass_idx < PASS_W'(NUM_PASS - 1)) begin
                            w_pass_next  = r_pass_idx + PASS_W'(1);
                            w_state_next = ST_WAIT_EST;
                        end else begin
                            w_state_next = ST_DONE;
                        end
                    end else begin
                        w_step_next = r_step_idx + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                // done is registered, so it appears together with the return to IDLE
                w_state_next = ST_IDLE;
                w_done_next  = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        w_busy_next = (w_state_next != ST_IDLE);
    end

    // Step program: controls for the step about to be executed
    always_comb begin
        w_prog_sel   = SEL_ZERO;
        w_prog_shift = SH_NONE;
        w_prog_load  = 1'b0;
        w_prog_emit  = 1'b0;
        case (w_step_next)
            3'd0: begin w_prog_sel = SEL_2E1; w_prog_load  = 1'b1; end
            3'd1: begin w_prog_sel = SEL_REG; w_prog_shift = SH_ONE;  w_prog_emit = 1'b1; end
            3'd2: begin w_prog_sel = SEL_2E2; w_prog_load  = 1'b1; end
            3'd3: begin w_prog_sel = SEL_REG; w_prog_shift = SH_HALF; w_prog_emit = 1'b1; end
            3'd4: begin w_prog_sel = SEL_E1; end
            3'd5: begin w_prog_sel = SEL_4E4; w_prog_load  = 1'b1; end
            3'd6: begin w_prog_sel = SEL_NE3; w_prog_emit  = 1'b1; end
            default: begin w_prog_sel = SEL_ZERO; end
        endcase
    end

    // Mux controls follow the program only in RUN; elsewhere the mux outputs zero
    always_comb begin
        w_sel_next   = SEL_ZERO;
        w_shift_next = SH_NONE;
        w_load_next  = 1'b0;
        w_valid_next = 1'b0;
        if (w_state_next == ST_RUN) begin
            w_sel_next   = w_prog_sel;
            w_shift_next = w_prog_shift;
            w_load_next  = w_prog_load;
            w_valid_next = w_prog_emit;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_step_idx  <= 3'd0;
            r_pass_idx  <= '0;
            r_sel       <= SEL_ZERO;
            r_shift     <= SH_NONE;
            r_reg_load  <= 1'b0;
            r_out_valid <= 1'b0;
            r_est_ack   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_step_idx  <= w_step_next;
            r_pass_idx  <= w_pass_next;
            r_sel       <= w_sel_next;
            r_shift     <= w_shift_next;
            r_reg_load  <= w_load_next;
            r_out_valid <= w_valid_next;
            r_est_ack   <= w_est_ack_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    assign sel       = r_sel;
    assign shift     = r_shift;
    assign reg_load  = r_reg_load;
    assign out_valid = r_out_valid;
    assign est_ack   = r_est_ack;
    assign step_idx  = r_step_idx;
    assign pass_idx  = r_pass_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/interp_add_seq.md
# interp_add_seq

Sequencer for the channel-estimation interpolation adder. It drives the operand-select (`sel`) and scaling (`shift`) controls of the add2_a operand mux, plus the load strobe of the shared `reg_2E` register. It walks a fixed 7-step micro-program once per interpolation pass and handshakes each emitted interpolated estimate to the downstream buffer. It sits between the LS pilot-estimate stage, which supplies E1..E4, and the interpolated-channel buffer.

## Interface
- `NUM_PASS`, default 2: passes per start; one pass per pilot set.
- `PASS_W`, default 1: width of `pass_idx`; must be ≥ clog2(`NUM_PASS`), min 1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin `NUM_PASS` passes; ignored unless IDLE.
- `est_valid`  in  1  E1..E4 are stable and usable for the next pass.
- `est_ack`  out  1  one-cycle pulse; current E1..E4 are consumed.
- `sel`  out  3  add2_a operand select.
- `shift`  out  2  add2_a `reg_E` scaling: 1 = pass-through, 2 = halve.
- `reg_load`  out  1  latch adder sum into shared `reg_2E` at the next edge.
- `out_valid`  out  1  adder sum this cycle is an interpolated estimate.
- `out_ready`  in  1  downstream accepts the estimate.
- `step_idx`  out  3  current micro-step, 0..6.
- `pass_idx`  out  `PASS_W`  current pass.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last pass completes.

## Operation
- FSM states: IDLE, WAIT_EST, RUN, DONE.
- IDLE → WAIT_EST on `start`. `pass_idx` is set to 0.
- WAIT_EST → RUN when `est_valid` = 1. Pulse `est_ack`. Set `step_idx` to 0.
- RUN executes the step program below. In each step line the fields are sel, shift, then flags.
  - Step 0: 000 (2E1), shift 0, `reg_load`.
  - Step 1: 100, shift 1 (`reg_E`), emit.
  - Step 2: 011 (2E2), shift 0, `reg_load`.
  - Step 3: 100, shift 2 (`reg_E`/2), emit.
  - Step 4: 001 (E1), shift 0.
  - Step 5: 010 (4E4), shift 0, `reg_load`.
  - Step 6: 110 (~E3), shift 0, emit.
- Emit steps assert `out_valid`. The step advances only when `out_valid && out_ready`.
  - While stalled, `sel`, `shift` and `step_idx` hold.
  - `reg_load` is never asserted on an emit step, so a stall cannot corrupt `reg_2E`.
- Non-emit steps advance unconditionally, one step per cycle.
- After step 6 is accepted:
  - If `pass_idx` < `NUM_PASS`-1: increment `pass_idx` and go to WAIT_EST.
  - Otherwise: go to DONE.
- DONE pulses `done` for one cycle, then returns to IDLE.
- In IDLE, WAIT_EST and DONE:
  - `sel` = 111, so the mux default outputs 0.
  - `shift` = 0; `reg_load` = 0; `out_valid` = 0.
- `start` while busy is ignored; it is not queued.
- `est_valid` is sampled only in WAIT_EST.
- `out_ready` is ignored outside emit steps.

## Timing
- All outputs are registered.
- Reset values:
  - `sel` = 111, `shift` = 0, `step_idx` = 0, `pass_idx` = 0.
  - `est_ack`, `reg_load`, `out_valid`, `busy`, `done` = 0.
  - State = IDLE.
- Asserting `rst_n` low mid-pass forces the reset values immediately (asynchronous). No partial pass resumes after reset is released.
- `start` seen at edge t → `busy` = 1 at t+1.
- `est_valid` seen in WAIT_EST at edge t → `est_ack` = 1 and step-0 controls at t+1.
- No-stall pass: 7 cycles in RUN. Total start → `done` = 1 + `NUM_PASS`·(1 + 7) + 1 cycles, assuming `est_valid` is already high.
- `est_ack` is high for exactly one cycle per pass.
- If `est_valid` is high on consecutive passes, WAIT_EST lasts one cycle.
- `done` and `busy` are mutually exclusive on a given cycle:
  - `done` = 1 occurs with `busy` = 0.
  - `busy` stays high through the last emit.

## Structure
- Shared package `interp_pkg` holds:
  - State encoding.
  - Sel constants: SEL_2E1 = 000, SEL_E1 = 001, SEL_2E2 = 011, SEL_4E4 = 010, SEL_NE3 = 110, SEL_REG = 100, SEL_ZERO = 111.
  - Shift constants: SH_ONE = 1, SH_HALF = 2.
  - `LAST_STEP` = 6.
- The step program is a `case` on `step_idx` inside the block. No sub-module is needed.

## Test plan
- Reset mid-operation:
  - Stimulus: `rst_n` low during RUN step 3.
  - Required: `sel` = 111 immediately; `out_valid` = 0; `busy` = 0; next `start` restarts at pass 0, step 0.
- No-stall 2-pass run:
  - Stimulus: `NUM_PASS` = 2, `est_valid` tied high, `out_ready` tied high.
  - Required: `sel` sequence 000,100,011,100,001,010,110 twice; `out_valid` at steps 1, 3, 6; `done` exactly 18 cycles after `start`.
- Back-pressure:
  - Stimulus: `out_ready` = 0 for 4 cycles at step 3.
  - Required: `sel` = 100, `shift` = 2 and `out_valid` = 1 held for 4 cycles, no `reg_load`; step 4 follows one cycle after `out_ready` rises.
- Estimate wait:
  - Stimulus: `est_valid` low for 5 cycles before pass 1.
  - Required: `sel` = 111 and `busy` = 1 throughout; one `est_ack` pulse; `pass_idx` = 1.
- Start while busy:
  - Stimulus: `start` pulsed at pass 0, step 2.
  - Required: no effect; exactly one `done`.
- Golden arithmetic with the mux connected:
  - Stimulus: E1 = 5, E2 = −3, E3 = 7, E4 = 2.
  - Required: emitted values checked against the reference model, including the ~E3 step (= −8).
